// File: rtl/edge_pkg.sv
// Shared definitions for the line_window_3x3 / edge_detect pixel path.
// Frame geometry defaults, coordinate widths and the window slice index.
package edge_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int ROW_W      = 9;
  localparam int COL_W      = 10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } lw_state_e;

  // Window pixel (row i, col j) lives at slice [DW*win_idx(i,j) +: DW].
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-line pixel store: one read port, one write port, synchronous read.
// A read and write to the same address in one cycle returns the old data.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/line_window_3x3.sv
// Raster-order 3x3 window generator: two line RAMs plus column shifters.
// Emits one window per accepted pixel once two lines and two columns exist.
module line_window_3x3
  import edge_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DW-1:0]     in_pix,
  output logic              out_valid,
  output logic [9*DW-1:0]   out_win,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              frame_err
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [COL_W-1:0] C_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] R_LAST = ROW_W'(HEIGHT - 1);

  lw_state_e        state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             err_q, err_d;

  logic             acc;
  logic [ROW_W-1:0] acc_r;
  logic [COL_W-1:0] acc_c;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    acc     = 1'b0;
    acc_r   = row_q;
    acc_c   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            acc   = 1'b1;
            acc_r = '0;
            acc_c = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          acc = 1'b1;
          // Early start-of-frame restarts the raster in place.
          if (in_sof) begin
            err_d = 1'b1;
            acc_r = '0;
            acc_c = '0;
          end
        end
      end
      default: ;
    endcase
    if (acc) begin
      state_d = S_RUN;
      if (acc_c == C_LAST) begin
        col_d = '0;
        if (acc_r == R_LAST) begin
          row_d   = '0;
          state_d = S_IDLE;
        end else begin
          row_d = acc_r + ROW_W'(1);
        end
      end else begin
        col_d = acc_c + COL_W'(1);
        row_d = acc_r;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end

  logic [DW-1:0]    lb0_rd, lb1_rd;
  logic             tok1_q;
  logic [DW-1:0]    pix1_q;
  logic [ROW_W-1:0] row1_q;
  logic [COL_W-1:0] col1_q;

  line_ram #(.DEPTH(WIDTH), .DW(DW)) u_lb0 (
    .clk_i     (clk),
    .rd_en_i   (acc),
    .rd_addr_i (acc_c[AW-1:0]),
    .rd_data_o (lb0_rd),
    .wr_en_i   (acc),
    .wr_addr_i (acc_c[AW-1:0]),
    .wr_data_i (in_pix)
  );

  // lb1 takes the displaced lb0 word once it has been read out.
  line_ram #(.DEPTH(WIDTH), .DW(DW)) u_lb1 (
    .clk_i     (clk),
    .rd_en_i   (acc),
    .rd_addr_i (acc_c[AW-1:0]),
    .rd_data_o (lb1_rd),
    .wr_en_i   (tok1_q),
    .wr_addr_i (col1_q[AW-1:0]),
    .wr_data_i (lb0_rd)
  );

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      tok1_q <= 1'b0;
      pix1_q <= '0;
      row1_q <= '0;
      col1_q <= '0;
    end else begin
      tok1_q <= acc;
      if (acc) begin
        pix1_q <= in_pix;
        row1_q <= acc_r;
        col1_q <= acc_c;
      end
    end
  end

  logic [8:0][DW-1:0] sh_q;
  logic               tok2_q;
  logic [ROW_W-1:0]   row2_q;
  logic [COL_W-1:0]   col2_q;
  logic               emit1;

  assign emit1 = tok1_q && (row1_q >= ROW_W'(2)) && (col1_q >= COL_W'(2));

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_q   <= '0;
      tok2_q <= 1'b0;
      row2_q <= '0;
      col2_q <= '0;
    end else begin
      tok2_q <= emit1;
      if (tok1_q) begin
        for (int i = 0; i < 3; i++) begin
          sh_q[win_idx(i, 0)] <= sh_q[win_idx(i, 1)];
          sh_q[win_idx(i, 1)] <= sh_q[win_idx(i, 2)];
        end
        sh_q[win_idx(0, 2)] <= lb1_rd;
        sh_q[win_idx(1, 2)] <= lb0_rd;
        sh_q[win_idx(2, 2)] <= pix1_q;
        row2_q <= row1_q - ROW_W'(1);
        col2_q <= col1_q - COL_W'(1);
      end
    end
  end

  logic               vld_q;
  logic [9*DW-1:0]    win_q;
  logic [ROW_W-1:0]   orow_q;
  logic [COL_W-1:0]   ocol_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_q  <= 1'b0;
      win_q  <= '0;
      orow_q <= '0;
      ocol_q <= '0;
    end else begin
      vld_q <= tok2_q;
      if (tok2_q) begin
        win_q  <= sh_q;
        orow_q <= row2_q;
        ocol_q <= col2_q;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_win   = win_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;
  assign frame_err = err_q;

endmodule
